seq_cla_adder: RTL and testbench
================================

Name: seq_cla_adder

Overview:
Multi-cycle N-bit adder/subtractor controller. It time-shares a single 4-bit carry-lookahead nibble adder (`cla`) across WIDTH/4 cycles. The controller latches operands through a valid/ready handshake, sequences nibbles LSB-first and ripples the carry through a register. It presents sum, carry-out and signed overflow on a valid/ready result port. It sits between operand producers and consumers in the arithmetic datapath wherever area matters more than latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 4 (elaboration error otherwise)
NIBBLES, WIDTH/4, derived localparam; number of RUN cycles per operation

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  controller can accept operands; high only in IDLE and forced 0 while rst is high
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for add; ignored when sub=1
sub  input  1  1 = compute A - B (B inverted, carry-in forced 1)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result
cout  output  1  carry-out of MSB nibble; for sub, 1 = no borrow
overflow  output  1  two's-complement signed overflow
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE; out_valid=0, sum=0, cout=0, overflow=0, busy=0, nibble index=0, carry reg=0. in_ready=0 while rst is high and 1 after release. Reset mid-RUN or mid-DONE aborts the operation and no result is presented.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready the controller registers a, b_eff = sub ? ~b : b, and carry = sub ? 1 : cin. It also clears the nibble index, then goes to RUN. in_valid without acceptance has no effect.
- RUN: in_ready=0. Each cycle the controller:
  - drives `cla` with a[4i+3:4i], b_eff[4i+3:4i] and the carry reg;
  - writes S into sum[4i+3:4i];
  - loads `cla` Cout into the carry reg;
  - increments i.
- RUN exit: after the cycle with i=NIBBLES-1, go to DONE, set out_valid=1, cout=final Cout, overflow=(a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]). The index wraps to 0 and is never out of range.
- Latency: operands accepted on edge k means out_valid is high after edge k+NIBBLES. With WIDTH=4 that is a single RUN cycle.
- DONE: sum, cout and overflow are held stable while out_valid && !out_ready. On out_ready, out_valid drops at the next edge and the state returns to IDLE. The next accept can happen at the earliest one cycle later, giving a throughput of 1 op per NIBBLES+2 cycles.
- Simultaneous events:
  - in_valid during RUN/DONE is ignored; the requester must hold it until in_ready.
  - out_ready while out_valid=0 is ignored.
- sum bits of nibbles not yet processed hold stale values during RUN and are only defined when out_valid=1.
- All arithmetic is modulo 2^WIDTH; no saturation.

Decomposition:
- Package seq_add_pkg:
  - state enum (IDLE, RUN, DONE);
  - NIBBLE_W=4 constant;
  - function computing index width = max(1, $clog2(NIBBLES)).
- Sub-module: one instance of the existing 4-bit carry-lookahead adder `cla` (A, B, Cin -> S, Cout), with no change to it. Everything else (FSM, operand/result registers, carry reg, index counter) lives in seq_cla_adder.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0FFF, sub=0, cin=0 -> after 4 RUN cycles: sum=0x2233, cout=0, overflow=0; out_valid rises exactly 4 edges after accept.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. Same with a=0x7FFF -> sum=0x8000, cout=0, overflow=1.
- sub=1: a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, overflow=0. a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, overflow=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> sum/cout/overflow stable, in_ready=0, a new in_valid is ignored. Assert out_ready -> IDLE next edge, then the pending request is accepted.
- Assert rst asynchronously mid-RUN (after nibble 2) -> out_valid=0, sum=0, state IDLE immediately. After release, in_ready=1 and a fresh op 0x00FF+0x0001 gives 0x0100.
- WIDTH=4 instance: a=0x9, b=0x8, cin=1 -> one RUN cycle, sum=0x2, cout=1, overflow=1.

Source files
------------

// File: rtl/seq_cla_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial CLA adder.
package seq_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    function automatic int idx_width(input int nibbles);
        return (nibbles <= 1) ? 1 : $clog2(nibbles);
    endfunction

endpackage

// File: rtl/seq_cla_adder_cla.sv
// 4-bit carry-lookahead adder: all internal carries from generate/propagate terms.
module cla (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    logic [3:0] g, p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    assign c[0] = Cin;
    assign c[1] = g[0] | (p[0] & Cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & Cin);

    assign S    = p ^ c[3:0];
    assign Cout = c[4];
endmodule

// File: rtl/seq_cla_adder.sv
// WIDTH-bit add/sub built by time-sharing one 4-bit CLA over WIDTH/4 cycles, LSB nibble first.
module seq_cla_adder
    import seq_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);
    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    generate
        if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
            $error("seq_cla_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic                carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NIBBLE_W-1:0] nib_a, nib_b, cla_s;
    logic                cla_co;

    assign nib_a = a_q[idx_q*NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[idx_q*NIBBLE_W +: NIBBLE_W];

    cla u_cla (
        .A   (nib_a),
        .B   (nib_b),
        .Cin (carry_q),
        .S   (cla_s),
        .Cout(cla_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction folds into the adder as A + ~B + 1.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*NIBBLE_W +: NIBBLE_W] = cla_s;
                carry_d = cla_co;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                    cout_d  = cla_co;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cla_s[NIBBLE_W-1] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_seq_cla_adder.sv
// Directed-vector bench for the 16-bit and 4-bit nibble-serial adders.
module tb_seq_cla_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
    logic [15:0] a = '0, b = '0, sum;
    logic        out_valid, out_ready = 1'b0, cout, overflow, busy;

    logic        n_in_valid = 1'b0, n_in_ready, n_cin = 1'b0, n_sub = 1'b0;
    logic [3:0]  n_a = '0, n_b = '0, n_sum;
    logic        n_out_valid, n_out_ready = 1'b0, n_cout, n_overflow, n_busy;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    seq_cla_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow), .busy(busy)
    );

    seq_cla_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
        .a(n_a), .b(n_b), .cin(n_cin), .sub(n_sub), .out_valid(n_out_valid),
        .out_ready(n_out_ready), .sum(n_sum), .cout(n_cout), .overflow(n_overflow), .busy(n_busy)
    );

    task automatic test_reset();
        #2;
        vectors++;
        if ({in_ready, out_valid, sum, cout, overflow, busy} !== 21'd0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b ov=%b sum=%h co=%b of=%b busy=%b, required all 0",
                     in_ready, out_valid, sum, cout, overflow, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || n_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b/%b, required 1/1", in_ready, n_in_ready);
        end
    endtask

    // Accept one op, measure latency, check result, then drain it.
    task automatic run_op(input string nm, input logic [15:0] ta, input logic [15:0] tb_,
                          input logic tcin, input logic tsub,
                          input logic [15:0] esum, input logic ecout, input logic eovf);
        int lat;
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        a = ta; b = tb_; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        vectors++;
        if (lat != 4) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges, required 4", nm, lat);
        end
        vectors++;
        if (sum !== esum || cout !== ecout || overflow !== eovf) begin
            errors++;
            $display("FAIL %s_result: sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                     nm, sum, cout, overflow, esum, ecout, eovf);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_drain: out_valid=%b in_ready=%b, required 0/1", nm, out_valid, in_ready);
        end
    endtask

    task automatic test_add();
        run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("add_cin",   16'h0001, 16'h0002, 1'b1, 1'b0, 16'h0004, 1'b0, 1'b0);
    endtask

    task automatic test_sub();
        run_op("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub_zero",  16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int guard;
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        // New request arrives while the result is stalled.
        a = 16'h0003; b = 16'h0004; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || sum !== 16'h3333 || cout !== 1'b0 || overflow !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ov=%b sum=%h co=%b of=%b rdy=%b, required 1 3333 0 0 0",
                         i, out_valid, sum, cout, overflow, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: ov=%b rdy=%b busy=%b, required 0 1 0", out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_pending_accept: busy=%b rdy=%b, required 1 0", busy, in_ready);
        end
        guard = 0;
        while (out_valid !== 1'b1 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        vectors++;
        if (out_valid !== 1'b1 || sum !== 16'h0007) begin
            errors++;
            $display("FAIL bp_pending_result: ov=%b sum=%h, required 1 0007", out_valid, sum);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || sum !== 16'h0000 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_run: ov=%b sum=%h busy=%b rdy=%b, required 0 0000 0 0",
                     out_valid, sum, busy, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: rdy=%b ov=%b, required 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    endtask

    task automatic test_width4();
        int lat;
        n_a = 4'h9; n_b = 4'h8; n_cin = 1'b1; n_sub = 1'b0; n_in_valid = 1'b1;
        @(posedge clk); #1;
        n_in_valid = 1'b0;
        lat = 0;
        while (n_out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        vectors++;
        if (lat != 1) begin
            errors++;
            $display("FAIL w4_latency: got %0d edges, required 1", lat);
        end
        vectors++;
        if (n_sum !== 4'h2 || n_cout !== 1'b1 || n_overflow !== 1'b1) begin
            errors++;
            $display("FAIL w4_result: sum=%h cout=%b ovf=%b, required 2 1 1", n_sum, n_cout, n_overflow);
        end
        n_out_ready = 1'b1;
        @(posedge clk); #1;
        n_out_ready = 1'b0;
        vectors++;
        if (n_out_valid !== 1'b0 || n_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL w4_drain: ov=%b rdy=%b, required 0 1", n_out_valid, n_in_ready);
        end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid_run();
        test_width4();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
